// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 INCR-burst slave over a MEMORY_DEPTH x DATA_WIDTH word RAM; optional range checking via macro AXI_RANGE_CHECK_EN.
// Latency: WREADY 1 cycle after AW, BVALID 1 cycle after last W, beat 0 on R 1 cycle after AR, then one R beat per cycle.
// Backpressure: one burst outstanding per direction; AWREADY/ARREADY low while busy; B and R outputs held stable until BREADY/RREADY.
module axi4_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // write address channel
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    input  logic                  WLAST,
    output logic                  WREADY,
    // write response channel
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int                  IDX_W       = $clog2(MEMORY_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W     = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Word index of a beat; the sum is one bit wider than the address so it never overflows,
    // and the modulo wraps accesses that run past the end of the RAM.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [7:0]            beat);
        logic [ADDR_WIDTH:0] sum;
        sum      = (ADDR_WIDTH+1)'(addr >> 2) + (ADDR_WIDTH+1)'(beat);
        word_idx = IDX_W'(sum % DEPTH_W);
    endfunction

`ifdef AXI_RANGE_CHECK_EN
    // A burst is illegal if it runs past the RAM or crosses a 4 KB boundary.
    function automatic logic range_err(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0]            len);
        logic [ADDR_WIDTH:0] end_idx;
        logic [13:0]         end_off;
        end_idx   = (ADDR_WIDTH+1)'(addr >> 2) + (ADDR_WIDTH+1)'(len) + (ADDR_WIDTH+1)'(1);
        end_off   = 14'(addr[11:0]) + ((14'(len) + 14'd1) << 2);
        range_err = (end_idx > DEPTH_W) || (end_off > 14'd4096);
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // write engine state
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_last_err;

    // read engine state
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [7:0]            r_cnt;
    logic                  r_err;

    logic                  aw_err_c;
    logic                  ar_err_c;
    logic                  w_final;
    logic                  wlast_bad;
    logic                  mem_we;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  unused_size;

`ifdef AXI_RANGE_CHECK_EN
    assign aw_err_c = range_err(AWADDR, AWLEN);
    assign ar_err_c = range_err(ARADDR, ARLEN);
`else
    assign aw_err_c = 1'b0;
    assign ar_err_c = 1'b0;
`endif

    // Transfer size is accepted on the bus but the stride is always one word.
    assign unused_size = ^{AWSIZE, ARSIZE};

    assign w_final   = (w_cnt == aw_len);
    assign wlast_bad = WLAST ^ w_final;
    assign mem_we    = (w_state == W_DATA) && WVALID && WREADY && !w_err;
    assign wr_idx    = word_idx(aw_addr, w_cnt);

    // In idle the read port looks up beat 0 of the incoming AR; during a burst it prefetches the next beat.
    assign rd_idx = (r_state == R_IDLE) ? word_idx(ARADDR, 8'd0)
                                        : word_idx(ar_addr, r_cnt + 8'd1);

    // RAM write port; deliberately unreset so contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[wr_idx] <= WDATA;
        end
    end

    // Write engine: AW acceptance, beat counting, WLAST checking and B response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state    <= W_IDLE;
            aw_addr    <= '0;
            aw_len     <= '0;
            w_cnt      <= '0;
            w_err      <= 1'b0;
            w_last_err <= 1'b0;
            AWREADY    <= 1'b0;
            WREADY     <= 1'b0;
            BVALID     <= 1'b0;
            BRESP      <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        aw_addr    <= AWADDR;
                        aw_len     <= AWLEN;
                        w_cnt      <= '0;
                        w_err      <= aw_err_c;
                        w_last_err <= 1'b0;
                        AWREADY    <= 1'b0;
                        WREADY     <= 1'b1;
                        w_state    <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY) begin
                        if (w_final) begin
                            // The burst ends on the AWLEN count regardless of WLAST.
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= (w_err || w_last_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                            if (wlast_bad) begin
                                w_last_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= RESP_OKAY;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: AR acceptance and R beat sequencing with a one-beat registered output.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ar_addr <= '0;
            ar_len  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        ar_addr <= ARADDR;
                        ar_len  <= ARLEN;
                        r_cnt   <= '0;
                        r_err   <= ar_err_c;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RDATA   <= ar_err_c ? '0 : mem[rd_idx];
                        RRESP   <= ar_err_c ? RESP_SLVERR : RESP_OKAY;
                        RLAST   <= (ARLEN == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RDATA   <= '0;
                            RRESP   <= RESP_OKAY;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            RDATA <= r_err ? '0 : mem[rd_idx];
                            RLAST <= ((r_cnt + 8'd1) == ar_len);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
